rr_arbiter4: RTL and testbench
==============================

RR_ARBITER4 -- requirements
Module: rr_arbiter4

Interface
REQ-001 The block SHALL have parameter MAX_HOLD, default 8, setting the maximum consecutive cycles one owner may hold a grant (legal range 1..255).
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-004 The block SHALL have port req, input, 4 bits, one request line per requester (bit i = requester i).
REQ-005 The block SHALL have port done, input, 4 bits, owner release strobe (bit i meaningful only while gnt[i]=1).
REQ-006 The block SHALL have port gnt, output, 4 bits, registered grant, one-hot or all-zero.
REQ-007 The block SHALL have port busy, output, 1 bit, high exactly while any gnt bit is high.
REQ-008 The block SHALL have port contend, output, 1 bit, registered flag: 2 or 3 req bits were high in the previous cycle.
REQ-009 The block SHALL have port full, output, 1 bit, registered flag: all 4 req bits were high in the previous cycle.
REQ-010 The block SHALL have port timeout, output, 1 bit, one-cycle pulse marking a forced release.

Function
REQ-011 The block SHALL implement states IDLE (no grant) and GRANT (one owner), with registered owner index, 2-bit round-robin pointer ptr, and hold counter hcnt sized for 0..MAX_HOLD.
REQ-012 In IDLE with req != 0 at edge k, the block SHALL enter GRANT and assert gnt one-hot for the first set req bit scanning ptr, ptr+1, ... mod 4, visible after edge k (1-cycle latency).
REQ-013 In IDLE with req == 0, the block SHALL stay in IDLE with gnt = 0.
REQ-014 On entering GRANT, hcnt SHALL load 1; each further cycle in GRANT without release increments hcnt.
REQ-015 In GRANT the block SHALL release (gnt -> 0 next edge, state -> IDLE) when done[owner]=1, or req[owner]=0, or hcnt == MAX_HOLD.
REQ-016 A release SHALL set ptr to (owner+1) mod 4, so the releasing owner has lowest priority in the next arbitration.
REQ-017 The block SHALL spend exactly one cycle with gnt = 0 between consecutive grants (no back-to-back handoff).
REQ-018 timeout SHALL pulse high for exactly the cycle after edge where the release was caused only by hcnt == MAX_HOLD (done[owner]=0 and req[owner]=1).
REQ-019 If done[owner] and hcnt == MAX_HOLD coincide, the release SHALL count as normal (timeout stays 0).
REQ-020 done bits of non-owners and done in IDLE SHALL be ignored; req changes of non-owners during GRANT SHALL not affect the current grant.
REQ-021 With MAX_HOLD = 1, every grant SHALL last exactly one cycle.
REQ-022 contend and full SHALL be computed from the popcount of req every cycle, independent of state, and registered so outputs never glitch; contend = popcount in {2,3}, full = popcount == 4, both 0 for popcount 0 or 1.
REQ-023 gnt SHALL never have more than one bit set in any cycle.

Reset
REQ-024 With rst=1 at an edge, after that edge gnt=0, busy=0, contend=0, full=0, timeout=0, state=IDLE, ptr=0, hcnt=0, taking priority over all other inputs.
REQ-025 Reset asserted mid-grant SHALL drop gnt at the same edge with no timeout pulse; first arbitration after reset starts from requester 0.

Verification
REQ-026 Reset, then req=4'b1010 held, done=0 -> gnt=4'b0010 one cycle later, held 8 cycles, timeout pulse, idle cycle, then gnt=4'b1000.
REQ-027 req=4'b1111 held, each owner asserts done in its 2nd grant cycle -> grant order 0,1,2,3,0 with one idle cycle between each, full=1 throughout, contend=0.
REQ-028 req sequence 0001, 0011, 0111, 1111, 0000 on successive cycles -> contend 0,1,1,0,0 and full 0,0,0,1,0, each one cycle delayed.
REQ-029 Owner 2 granted, req[2] dropped at cycle 3 of grant -> gnt=0 next cycle, timeout=0, ptr=3.
REQ-030 done[2] and hcnt==MAX_HOLD on same edge -> release with timeout=0; rst=1 during a grant -> gnt=0 after that edge, next grant to lowest-index requester.

Source files
------------

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with a bounded hold time per grant.
// Registered one-hot grant, forced-release pulse and request-population flags.
module rr_arbiter4 #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [3:0] done,
  output logic [3:0] gnt,
  output logic       busy,
  output logic       contend,
  output logic       full,
  output logic       timeout
);

  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_LIM = HW'(MAX_HOLD);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state;
  logic [1:0]      owner;
  logic [1:0]      ptr;
  logic [HW-1:0]   hcnt;

  logic [1:0]      pick;
  logic [2:0]      req_cnt;
  logic            hold_hit;
  logic            rel;

  // First set request scanning ptr, ptr+1, ... (mod 4); smallest offset wins.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    idx = p;
    for (int i = 3; i >= 0; i--) begin
      if (r[p + 2'(i)]) idx = p + 2'(i);
    end
    return idx;
  endfunction

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

  always_comb begin
    pick     = rr_pick(req, ptr);
    req_cnt  = popcount4(req);
    hold_hit = (hcnt == HOLD_LIM);
    rel      = done[owner] | ~req[owner] | hold_hit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      owner   <= 2'd0;
      ptr     <= 2'd0;
      hcnt    <= '0;
      gnt     <= 4'b0000;
      busy    <= 1'b0;
      contend <= 1'b0;
      full    <= 1'b0;
      timeout <= 1'b0;
    end else begin
      contend <= (req_cnt == 3'd2) || (req_cnt == 3'd3);
      full    <= (req_cnt == 3'd4);
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (|req) begin
            state <= GRANT;
            owner <= pick;
            gnt   <= 4'b0001 << pick;
            busy  <= 1'b1;
            hcnt  <= HW'(1);
          end
        end
        GRANT: begin
          if (rel) begin
            state   <= IDLE;
            gnt     <= 4'b0000;
            busy    <= 1'b0;
            ptr     <= owner + 2'd1;
            hcnt    <= '0;
            // Only a pure hold-limit expiry counts as forced.
            timeout <= hold_hit & req[owner] & ~done[owner];
          end else begin
            hcnt <= hcnt + HW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arbiter4.sv
// Bench for rr_arbiter4: directed vector table, hand sequences and random traffic
// against a behavioural model, on instances with MAX_HOLD = 8 and MAX_HOLD = 1.
module tb_rr_arbiter4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] done;
  logic [3:0] gnt8, gnt1;
  logic       busy8, busy1, contend8, contend1, full8, full1, timeout8, timeout1;

  always #5 clk = ~clk;

  rr_arbiter4 #(.MAX_HOLD(8)) dut8 (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .gnt(gnt8), .busy(busy8), .contend(contend8), .full(full8), .timeout(timeout8)
  );

  rr_arbiter4 #(.MAX_HOLD(1)) dut1 (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .gnt(gnt1), .busy(busy1), .contend(contend1), .full(full1), .timeout(timeout1)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %b, expected %b", nm, $time, act, exp);
    end
  endtask

  // Behavioural model: owner -1 means nobody holds the grant.
  int m_own[2], m_ptr[2], m_hold[2];
  int m_lim[2] = '{8, 1};
  bit m_to[2], m_c[2], m_f[2];

  task automatic model_step(input bit r, input logic [3:0] q, input logic [3:0] d);
    int w, o, n;
    for (int k = 0; k < 2; k++) begin
      m_to[k] = 1'b0;
      if (r) begin
        m_own[k] = -1; m_ptr[k] = 0; m_hold[k] = 0; m_c[k] = 1'b0; m_f[k] = 1'b0;
      end else begin
        n = $countones(q);
        m_c[k] = (n == 2 || n == 3);
        m_f[k] = (n == 4);
        o = m_own[k];
        if (o < 0) begin
          w = -1;
          for (int i = 0; i < 4; i++)
            if (w < 0 && q[(m_ptr[k] + i) % 4]) w = (m_ptr[k] + i) % 4;
          m_own[k] = w;
          if (w >= 0) m_hold[k] = 1;
        end else if (d[o] || !q[o] || m_hold[k] == m_lim[k]) begin
          m_to[k]  = (m_hold[k] == m_lim[k]) && !d[o] && q[o];
          m_ptr[k] = (o + 1) % 4;
          m_own[k] = -1;
          m_hold[k] = 0;
        end else begin
          m_hold[k]++;
        end
      end
    end
  endtask

  function automatic logic [3:0] m_gnt(input int k);
    return (m_own[k] < 0) ? 4'b0000 : 4'(1 << m_own[k]);
  endfunction

  task automatic model_compare();
    chk("gnt_h8",     gnt8,     m_gnt(0));
    chk("busy_h8",    {3'b0, busy8},    {3'b0, m_own[0] >= 0});
    chk("contend_h8", {3'b0, contend8}, {3'b0, m_c[0]});
    chk("full_h8",    {3'b0, full8},    {3'b0, m_f[0]});
    chk("timeout_h8", {3'b0, timeout8}, {3'b0, m_to[0]});
    chk("onehot_h8",  {3'b0, $countones(gnt8) <= 1}, 4'd1);
    chk("gnt_h1",     gnt1,     m_gnt(1));
    chk("busy_h1",    {3'b0, busy1},    {3'b0, m_own[1] >= 0});
    chk("contend_h1", {3'b0, contend1}, {3'b0, m_c[1]});
    chk("full_h1",    {3'b0, full1},    {3'b0, m_f[1]});
    chk("timeout_h1", {3'b0, timeout1}, {3'b0, m_to[1]});
  endtask

  task automatic cycle(input bit r, input logic [3:0] q, input logic [3:0] d);
    rst = r; req = q; done = d;
    @(posedge clk);
    #1;
    model_step(r, q, d);
    model_compare();
  endtask

  typedef struct {
    bit         rst;
    logic [3:0] req;
    logic [3:0] done;
    logic [3:0] gnt;
    bit         to;
    bit         c;
    bit         f;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input bit r, input logic [3:0] q, input logic [3:0] d,
                              input logic [3:0] g, input bit t, input bit c, input bit f);
    vec_t v;
    v.rst = r; v.req = q; v.done = d; v.gnt = g; v.to = t; v.c = c; v.f = f;
    tbl.push_back(v);
  endfunction

  initial begin
    rst = 1'b1; req = 4'b0; done = 4'b0;
    for (int k = 0; k < 2; k++) begin
      m_own[k] = -1; m_ptr[k] = 0; m_hold[k] = 0;
    end

    // Reset, then popcount flags on a growing request set.
    add(1, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0);
    add(0, 4'b0001, 4'b0000, 4'b0001, 0, 0, 0);
    add(0, 4'b0011, 4'b0000, 4'b0001, 0, 1, 0);
    add(0, 4'b0111, 4'b0000, 4'b0001, 0, 1, 0);
    add(0, 4'b1111, 4'b0000, 4'b0001, 0, 0, 1);
    add(0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0);
    // Hold-limit expiry on requester 1, then handoff to requester 3.
    add(1, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0);
    add(0, 4'b1010, 4'b0000, 4'b0010, 0, 1, 0);
    for (int i = 0; i < 7; i++) add(0, 4'b1010, 4'b0000, 4'b0010, 0, 1, 0);
    add(0, 4'b1010, 4'b0000, 4'b0000, 1, 1, 0);
    add(0, 4'b1010, 4'b0000, 4'b1000, 0, 1, 0);
    // Reset mid-grant; next grant from requester 0 upward.
    add(1, 4'b1010, 4'b0000, 4'b0000, 0, 0, 0);
    add(0, 4'b1010, 4'b0000, 4'b0010, 0, 1, 0);
    add(0, 4'b1010, 4'b1000, 4'b0010, 0, 1, 0);
    add(0, 4'b1010, 4'b0010, 4'b0000, 0, 1, 0);
    // Owner 2 drops its request in its third grant cycle; ptr lands on 3.
    add(0, 4'b0100, 4'b1111, 4'b0100, 0, 0, 0);
    add(0, 4'b0100, 4'b0000, 4'b0100, 0, 0, 0);
    add(0, 4'b0100, 4'b0000, 4'b0100, 0, 0, 0);
    add(0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0);
    add(0, 4'b1001, 4'b0000, 4'b1000, 0, 1, 0);
    // done coinciding with the hold limit is a normal release.
    for (int i = 0; i < 7; i++) add(0, 4'b1001, 4'b0000, 4'b1000, 0, 1, 0);
    add(0, 4'b1001, 4'b1000, 4'b0000, 0, 1, 0);
    add(0, 4'b1001, 4'b0000, 4'b0001, 0, 1, 0);

    foreach (tbl[i]) begin
      cycle(tbl[i].rst, tbl[i].req, tbl[i].done);
      chk($sformatf("vec%0d_gnt", i), gnt8, tbl[i].gnt);
      chk($sformatf("vec%0d_busy", i), {3'b0, busy8}, {3'b0, |tbl[i].gnt});
      chk($sformatf("vec%0d_timeout", i), {3'b0, timeout8}, {3'b0, tbl[i].to});
      chk($sformatf("vec%0d_contend", i), {3'b0, contend8}, {3'b0, tbl[i].c});
      chk($sformatf("vec%0d_full", i), {3'b0, full8}, {3'b0, tbl[i].f});
    end

    // All four requesting, each owner releases in its second grant cycle.
    cycle(1'b1, 4'b0000, 4'b0000);
    for (int k = 0; k < 5; k++) begin
      cycle(1'b0, 4'b1111, 4'b0000);
      chk($sformatf("rr%0d_grant", k), gnt8, 4'(1 << (k % 4)));
      chk($sformatf("rr%0d_full", k), {3'b0, full8}, 4'd1);
      chk($sformatf("rr%0d_contend", k), {3'b0, contend8}, 4'd0);
      cycle(1'b0, 4'b1111, 4'b0000);
      chk($sformatf("rr%0d_hold", k), gnt8, 4'(1 << (k % 4)));
      cycle(1'b0, 4'b1111, 4'(1 << (k % 4)));
      chk($sformatf("rr%0d_gap", k), gnt8, 4'b0000);
    end

    // Random traffic with sticky requests, sparse done strobes and rare resets.
    begin
      logic [3:0] q;
      q = 4'b0;
      for (int n = 0; n < 3000; n++) begin
        if ($urandom_range(0, 3) == 0) q = 4'($urandom_range(0, 15));
        cycle($urandom_range(0, 99) == 0, q,
              ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
